// File: rtl/fft_pkg.sv
// Shared types and default geometry for the FFT front end and fft_top.
package fft_pkg;

  localparam int FFT_DATA_W = 16;
  localparam int FFT_BANKS  = 4;
  localparam int FFT_DEPTH  = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/fft_bank_addr_gen.sv
// Maps a linear sample index to a one-hot bank select and in-bank address,
// in sequential (bank-major) or interleaved (bank-minor) order.
module fft_bank_addr_gen
  import fft_pkg::*;
#(
  parameter int BANKS  = FFT_BANKS,
  parameter int DEPTH  = FFT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(BANKS * DEPTH)
) (
  input  logic [CNT_W-1:0]  cnt,
  input  logic              ilv,
  output logic [BANKS-1:0]  we,
  output logic [ADDR_W-1:0] addr
);

  localparam int BANK_W = $clog2(BANKS);

  logic [BANK_W-1:0] bank;

  // Split the index into bank and address fields according to the order mode.
  always_comb begin
    if (ilv) begin
      bank = cnt[BANK_W-1:0];
      addr = cnt[CNT_W-1:BANK_W];
    end else begin
      bank = cnt[CNT_W-1:ADDR_W];
      addr = cnt[ADDR_W-1:0];
    end
    we       = '0;
    we[bank] = 1'b1;
  end

endmodule

// File: rtl/fft_sample_loader.sv
// Loads a valid-qualified sample stream into the banked FFT input RAM,
// pulses the FFT start, and waits for completion (optionally re-arming).
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int BANKS  = FFT_BANKS,
  parameter int DEPTH  = FFT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int FCNT_W = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iARM,
  input  logic              iCONT,
  input  logic              iILV,
  input  logic              iVALID,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oREADY,
  output logic [BANKS-1:0]  oWE,
  output logic [ADDR_W-1:0] oADDR_WR,
  output logic [DATA_W-1:0] oDATA,
  output logic              oFFT_START,
  input  logic              iFFT_RDY,
  output logic              oBUSY,
  output logic              oDROP,
  output logic [FCNT_W-1:0] oFRAME_CNT
);

  localparam int N     = BANKS * DEPTH;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ilv_q, ilv_d;
  logic                cont_q, cont_d;
  logic                rdy_q;
  logic                ready_q, ready_d;
  logic [BANKS-1:0]    we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  logic [BANKS-1:0]    gen_we;
  logic [ADDR_W-1:0]   gen_addr;
  logic                accept;
  logic                rdy_rise;

  fft_bank_addr_gen #(
    .BANKS  (BANKS),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .cnt  (cnt_q),
    .ilv  (ilv_q),
    .we   (gen_we),
    .addr (gen_addr)
  );

  // Next-state and registered-output computation for the load sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ilv_d    = ilv_q;
    cont_d   = cont_q;
    we_d     = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    start_d  = 1'b0;
    drop_d   = drop_q;
    fcnt_d   = fcnt_q;
    // ready_q is high exactly while in FILL, so acceptance needs no state term.
    accept   = iVALID && ready_q;
    rdy_rise = iFFT_RDY && !rdy_q;

    if (accept) begin
      we_d   = gen_we;
      addr_d = gen_addr;
      data_d = iDATA;
    end

    case (state_q)
      IDLE: begin
        if (iARM) begin
          ilv_d   = iILV;
          cont_d  = iCONT;
          cnt_d   = '0;
          drop_d  = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // First LAUNCH cycle raises the pulse; second leaves with it dropping.
        if (!start_q) start_d = 1'b1;
        else          state_d = WAIT;
      end
      WAIT: begin
        if (rdy_rise) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
          if (cont_q) begin
            ilv_d   = iILV;
            cont_d  = iCONT;
            cnt_d   = '0;
            state_d = FILL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == LAUNCH || state_q == WAIT) && cont_q && iVALID && !ready_q)
      drop_d = 1'b1;

    ready_d = (state_d == FILL);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ilv_q   <= 1'b0;
      cont_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ilv_q   <= ilv_d;
      cont_q  <= cont_d;
      rdy_q   <= iFFT_RDY;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign oREADY     = ready_q;
  assign oWE        = we_q;
  assign oADDR_WR   = addr_q;
  assign oDATA      = data_q;
  assign oFFT_START = start_q;
  assign oBUSY      = busy_q;
  assign oDROP      = drop_q;
  assign oFRAME_CNT = fcnt_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader with a write scoreboard.
module tb_fft_sample_loader;

  logic        iCLK = 1'b0;
  logic        iRESET, iARM, iCONT, iILV, iVALID, iFFT_RDY;
  logic [15:0] iDATA;
  logic        oREADY, oFFT_START, oBUSY, oDROP;
  logic [3:0]  oWE;
  logic [8:0]  oADDR_WR;
  logic [15:0] oDATA;
  logic [15:0] oFRAME_CNT;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  logic [28:0] exp_q[$];

  fft_sample_loader #(
    .DATA_W (16),
    .BANKS  (4),
    .DEPTH  (512),
    .ADDR_W (9),
    .FCNT_W (16)
  ) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iARM       (iARM),
    .iCONT      (iCONT),
    .iILV       (iILV),
    .iVALID     (iVALID),
    .iDATA      (iDATA),
    .oREADY     (oREADY),
    .oWE        (oWE),
    .oADDR_WR   (oADDR_WR),
    .oDATA      (oDATA),
    .oFFT_START (oFFT_START),
    .iFFT_RDY   (iFFT_RDY),
    .oBUSY      (oBUSY),
    .oDROP      (oDROP),
    .oFRAME_CNT (oFRAME_CNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference mapping: sequential fills each 512-word bank in turn,
  // interleaved rotates banks on every sample.
  function automatic logic [28:0] exp_wr(input int idx, input bit ilv);
    int bank;
    int addr;
    if (ilv) begin
      bank = idx % 4;
      addr = idx / 4;
    end else begin
      bank = idx / 512;
      addr = idx % 512;
    end
    return {4'(1 << bank), 9'(addr), 16'(idx)};
  endfunction

  // Advance one clock, then observe outputs away from the edge.
  task automatic tick();
    logic [28:0] e;
    @(posedge iCLK);
    #1;
    cyc++;
    if (oWE !== 4'b0000) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_we_addr_data", 64'({oWE, oADDR_WR, oDATA}), 64'(e));
      end
    end
    if (oFFT_START === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
    end
  endtask

  task automatic arm(input bit ilv, input bit cont);
    iARM = 1'b1;
    iILV = ilv;
    iCONT = cont;
    tick();
    iARM = 1'b0;
    chk("ready_after_arm", 64'(oREADY), 64'd1);
    chk("busy_after_arm", 64'(oBUSY), 64'd1);
  endtask

  task automatic send_frame(input bit ilv, input int gap_max, input int n, input int arm_at);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      iVALID = 1'b0;
      iARM = 1'b0;
      repeat (gap) tick();
      iVALID = 1'b1;
      iDATA = 16'(i);
      if (i == arm_at) begin
        iARM = 1'b1;
        iILV = ~ilv;
      end
      exp_q.push_back(exp_wr(i, ilv));
      tick();
    end
    iVALID = 1'b0;
    iARM = 1'b0;
  endtask

  task automatic wait_start();
    int s0;
    s0 = start_cnt;
    for (int i = 0; i < 8 && start_cnt == s0; i++) tick();
    chk("start_count", 64'(start_cnt - s0), 64'd1);
    chk("start_after_last_write", 64'(start_cyc - last_wr_cyc), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    tick();
    chk("start_width", 64'(oFFT_START), 64'd0);
    chk("ready_in_wait", 64'(oREADY), 64'd0);
  endtask

  task automatic complete();
    iFFT_RDY = 1'b1;
    tick();
    iFFT_RDY = 1'b0;
  endtask

  initial begin
    int w0;
    int s0;
    iRESET = 1'b1; iARM = 1'b0; iCONT = 1'b0; iILV = 1'b0;
    iVALID = 1'b0; iFFT_RDY = 1'b0; iDATA = '0;
    repeat (3) tick();
    chk("reset_outputs", 64'({oREADY, oWE, oADDR_WR, oDATA, oFFT_START, oBUSY, oDROP}), 64'd0);
    chk("reset_frame_cnt", 64'(oFRAME_CNT), 64'd0);
    iRESET = 1'b0;
    tick();

    // Sequential single frame.
    arm(1'b0, 1'b0);
    send_frame(1'b0, 0, 2048, -1);
    wait_start();
    chk("seq_busy_wait", 64'(oBUSY), 64'd1);
    complete();
    chk("seq_frame_cnt", 64'(oFRAME_CNT), 64'd1);
    chk("seq_idle_busy", 64'(oBUSY), 64'd0);

    // Interleaved frame with an ignored re-arm (and toggled order) mid-frame.
    arm(1'b1, 1'b0);
    send_frame(1'b1, 0, 2048, 100);
    wait_start();
    complete();
    chk("ilv_frame_cnt", 64'(oFRAME_CNT), 64'd2);
    chk("ilv_idle_busy", 64'(oBUSY), 64'd0);

    // Sequential frame with random input stalls.
    w0 = wr_cnt;
    arm(1'b0, 1'b0);
    send_frame(1'b0, 7, 2048, -1);
    wait_start();
    chk("stall_write_count", 64'(wr_cnt - w0), 64'd2048);
    complete();
    chk("stall_frame_cnt", 64'(oFRAME_CNT), 64'd3);

    // Continuous mode with completion already high before launch.
    iFFT_RDY = 1'b1;
    tick();
    arm(1'b0, 1'b1);
    send_frame(1'b0, 0, 2048, -1);
    iVALID = 1'b1;
    wait_start();
    repeat (10) tick();
    chk("prehigh_no_completion", 64'(oFRAME_CNT), 64'd3);
    chk("prehigh_busy", 64'(oBUSY), 64'd1);
    chk("prehigh_ready", 64'(oREADY), 64'd0);
    iFFT_RDY = 1'b0;
    repeat (10) tick();
    chk("drop_in_wait", 64'(oDROP), 64'd1);
    iVALID = 1'b0;
    iCONT = 1'b0;
    iILV = 1'b1;
    iFFT_RDY = 1'b1;
    tick();
    chk("cont_ready_refill", 64'(oREADY), 64'd1);
    chk("cont_frame_cnt", 64'(oFRAME_CNT), 64'd4);
    chk("cont_busy", 64'(oBUSY), 64'd1);
    send_frame(1'b1, 0, 2048, -1);
    wait_start();
    iFFT_RDY = 1'b0;
    tick();
    complete();
    chk("cont_frame_cnt2", 64'(oFRAME_CNT), 64'd5);
    chk("cont_idle_busy", 64'(oBUSY), 64'd0);
    chk("drop_sticky", 64'(oDROP), 64'd1);

    // Arm clears drop; reset mid-frame abandons the frame.
    arm(1'b0, 1'b0);
    chk("drop_cleared_by_arm", 64'(oDROP), 64'd0);
    send_frame(1'b0, 0, 1000, -1);
    iVALID = 1'b1;
    iDATA = 16'd1000;
    iRESET = 1'b1;
    tick();
    iVALID = 1'b0;
    chk("midreset_outputs", 64'({oREADY, oWE, oADDR_WR, oDATA, oFFT_START, oBUSY, oDROP}), 64'd0);
    chk("midreset_frame_cnt", 64'(oFRAME_CNT), 64'd0);
    chk("midreset_queue", 64'(exp_q.size()), 64'd0);
    iRESET = 1'b0;
    s0 = start_cnt;
    repeat (5) tick();
    chk("midreset_no_start", 64'(start_cnt - s0), 64'd0);
    chk("midreset_idle", 64'(oBUSY), 64'd0);
    arm(1'b0, 1'b0);
    send_frame(1'b0, 0, 2048, -1);
    wait_start();
    complete();
    chk("restart_frame_cnt", 64'(oFRAME_CNT), 64'd1);
    chk("restart_idle", 64'(oBUSY), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
